// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch front end.
// Owns the program counter, issues word-aligned fetch requests under a credit
// rule (buffered + in-flight <= DEPTH), tags each request with its address,
// buffers in-order responses in a small FIFO and presents (pc, instr) pairs
// downstream on a valid/ready handshake. A branch redirect flushes the FIFO and
// drops every response still in flight.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : a redirect to a non word-aligned target sets the sticky
//               misalign_err flag, flushes, keeps pc and parks the unit in HALT
//               (no further requests) until reset.
//   undefined : misalign_err is held at 0 and target bits [1:0] are cleared.
//
// Handshakes:
//   imem_req/imem_addr : a request is accepted in the cycle imem_req is high.
//   imem_rvalid        : one in-order response per cycle it is high.
//   instr_valid/ready  : the head transfers when both are high at a clock edge;
//                        instr_pc/instr_data hold steady while valid && !ready.
module pc_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [INSTR_W-1:0] instr_data,
  input  logic               instr_ready,
  output logic               misalign_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       outst_q, outst_d;
  logic [CW-1:0]       discard_q, discard_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       tag_wr_q, tag_wr_d;
  logic [PW-1:0]       tag_rd_q, tag_rd_d;
  logic                misalign_q, misalign_d;

  logic [ADDR_W-1:0]   tag_mem  [DEPTH];
  logic [ADDR_W-1:0]   pc_mem   [DEPTH];
  logic [INSTR_W-1:0]  data_mem [DEPTH];

  logic                halted;
  logic                credit_ok;
  logic                bad_target;
  logic                resp_live;
  logic                push;
  logic                pop;

  assign halted = (state_q == ST_HALT);

`ifdef FETCH_ALIGN_CHECK_EN
  assign bad_target = branch_taken && (branch_target[1:0] != 2'b00);
`else
  assign bad_target = 1'b0;
`endif

  // Credit rule: never have more fetches buffered plus in flight than FIFO slots.
  assign credit_ok = ({1'b0, count_q} + {1'b0, outst_q}) < (CW+1)'(DEPTH);
  assign imem_req  = !reset && !halted && !branch_taken && credit_ok;
  assign imem_addr = pc_q;

  // A response is live (owns a tag) only when nothing is pending discard.
  assign resp_live = imem_rvalid && (discard_q == '0);
  assign push      = resp_live && !branch_taken;
  assign pop       = instr_valid && instr_ready;

  assign instr_valid  = (count_q != '0);
  assign instr_pc     = pc_mem[rd_ptr_q];
  assign instr_data   = data_mem[rd_ptr_q];
  assign misalign_err = misalign_q;

  // FSM next state: RUN until a misaligned redirect parks the unit in HALT.
  always_comb begin
    state_d    = state_q;
    misalign_d = misalign_q;
    if (bad_target) begin
      state_d    = ST_HALT;
      misalign_d = 1'b1;
    end
  end

  // Program counter: redirect wins over sequential increment.
  always_comb begin
    pc_d = pc_q;
    if (branch_taken) begin
      if (!bad_target && !halted) begin
        pc_d = branch_target & ~(ADDR_W'(3));
      end
    end else if (imem_req) begin
      pc_d = pc_q + ADDR_W'(4);
    end
  end

  // In-flight bookkeeping: outstanding count, discard count and tag FIFO pointers.
  always_comb begin
    outst_d   = outst_q;
    discard_d = discard_q;
    tag_wr_d  = tag_wr_q + PW'(imem_req);
    tag_rd_d  = tag_rd_q + PW'(resp_live);
    if (imem_req && !imem_rvalid) begin
      outst_d = outst_q + CW'(1);
    end else if (!imem_req && imem_rvalid) begin
      outst_d = outst_q - CW'(1);
    end
    if (imem_rvalid && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end
    if (branch_taken) begin
      // Everything still in flight after this cycle belongs to the old path.
      discard_d = outst_d;
      tag_rd_d  = tag_wr_q;
    end
  end

  // Instruction FIFO occupancy and pointers; a redirect empties it.
  always_comb begin
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    if (branch_taken) begin
      count_d  = '0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = wr_ptr_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      misalign_q <= misalign_d;
    end
  end

  // Storage: request tags on issue, (tag, data) pairs on a kept response.
  always_ff @(posedge clk) begin
    if (imem_req) begin
      tag_mem[tag_wr_q] <= pc_q;
    end
    if (push) begin
      pc_mem[wr_ptr_q]   <= tag_mem[tag_rd_q];
      data_mem[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with an in-order fixed-latency memory model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [31:0] instr_data;
  logic        instr_ready = 1'b0;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;
  int neg_n  = 0;
  int lat    = 1;
  int req_cnt = 0;
  int base;
  logic [31:0] e;

  int          due_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] exp_q[$];

  pc_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_valid   (instr_valid),
    .instr_pc      (instr_pc),
    .instr_data    (instr_data),
    .instr_ready   (instr_ready),
    .misalign_err  (misalign_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // Memory model: requests seen at a negedge are accepted at the next posedge;
  // the response is driven at the negedge lat cycles later.
  always @(negedge clk) begin
    neg_n = neg_n + 1;
    if (reset) begin
      due_q.delete();
      addr_q.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end else begin
      imem_rvalid = 1'b0;
      if (due_q.size() > 0 && due_q[0] == neg_n) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(addr_q[0]);
        void'(due_q.pop_front());
        void'(addr_q.pop_front());
      end
      if (imem_req) begin
        due_q.push_back(neg_n + lat);
        addr_q.push_back(imem_addr);
        req_cnt = req_cnt + 1;
      end
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic rdy, input int l);
    go();
    reset = 1'b1;
    branch_taken = 1'b0;
    instr_ready = rdy;
    lat = l;
    go();
    go();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- reset state and latency-1 streaming ----
    do_reset(1'b1, 1);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_req", imem_req, 1);
    chk("rst_valid", instr_valid, 0);
    chk("rst_mis", misalign_err, 0);
    go();
    chk("t1_lat_valid", instr_valid, 0);
    for (int k = 0; k < 6; k++) exp_q.push_back(32'(4 * k));
    while (exp_q.size() > 0) begin
      go();
      e = exp_q.pop_front();
      chk("t1_valid", instr_valid, 1);
      chk("t1_pc", instr_pc, e);
      chk("t1_data", instr_data, mem_word(e));
    end

    // ---- backpressure: credit stops at 4 requests ----
    do_reset(1'b0, 1);
    base = req_cnt;
    repeat (10) go();
    chk("t2_reqs", 32'(req_cnt - base), 4);
    chk("t2_req_off", imem_req, 0);
    chk("t2_hold_valid", instr_valid, 1);
    chk("t2_hold_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    #1;
    chk("t2_d0_pc", instr_pc, 32'h0);
    go();
    chk("t2_d1_pc", instr_pc, 32'h4);
    chk("t2_d1_req", imem_req, 1);
    chk("t2_d1_addr", imem_addr, 32'h10);
    go();
    chk("t2_d2_pc", instr_pc, 32'h8);
    go();
    chk("t2_d3_pc", instr_pc, 32'hC);
    go();
    chk("t2_d4_pc", instr_pc, 32'h10);
    chk("t2_d4_data", instr_data, mem_word(32'h10));

    // ---- reset mid-stream with 3 buffered entries ----
    do_reset(1'b0, 1);
    repeat (4) go();
    chk("t4_pre_valid", instr_valid, 1);
    chk("t4_pre_pc", instr_pc, 32'h0);
    reset = 1'b1;
    go();
    reset = 1'b0;
    #1;
    chk("t4_valid", instr_valid, 0);
    chk("t4_addr", imem_addr, 32'h0);
    chk("t4_req", imem_req, 1);
    base = req_cnt;
    repeat (10) go();
    chk("t4_reqs", 32'(req_cnt - base), 4);

    // ---- redirect with two stale responses in flight (latency 3) ----
    do_reset(1'b1, 3);
    repeat (5) go();
    chk("t3_pre_valid", instr_valid, 1);
    chk("t3_pre_pc", instr_pc, 32'h4);
    branch_taken = 1'b1;
    branch_target = 32'h100;
    #1;
    chk("t3_br_req", imem_req, 0);
    go();
    branch_taken = 1'b0;
    #1;
    chk("t3_addr", imem_addr, 32'h100);
    chk("t3_req", imem_req, 1);
    chk("t3_c6_valid", instr_valid, 0);
    for (int k = 7; k <= 9; k++) begin
      go();
      chk("t3_gap_valid", instr_valid, 0);
    end
    go();
    chk("t3_valid", instr_valid, 1);
    chk("t3_pc", instr_pc, 32'h100);
    chk("t3_data", instr_data, mem_word(32'h100));
    go();
    chk("t3_pc2", instr_pc, 32'h104);

    // ---- back-to-back redirects, last wins ----
    do_reset(1'b1, 3);
    go();
    go();
    branch_taken = 1'b1;
    branch_target = 32'h200;
    #1;
    chk("t5_br1_req", imem_req, 0);
    go();
    branch_target = 32'h300;
    #1;
    chk("t5_br2_req", imem_req, 0);
    go();
    branch_taken = 1'b0;
    #1;
    chk("t5_addr", imem_addr, 32'h300);
    chk("t5_req", imem_req, 1);
    chk("t5_c4_valid", instr_valid, 0);
    for (int k = 5; k <= 7; k++) begin
      go();
      chk("t5_gap_valid", instr_valid, 0);
    end
    go();
    chk("t5_valid", instr_valid, 1);
    chk("t5_pc", instr_pc, 32'h300);
    chk("t5_data", instr_data, mem_word(32'h300));

    // ---- PC wrap ----
    do_reset(1'b1, 1);
    go();
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    #1;
    go();
    branch_taken = 1'b0;
    #1;
    chk("t7_addr_top", imem_addr, 32'hFFFF_FFFC);
    go();
    chk("t7_addr_wrap", imem_addr, 32'h0);
    chk("t7_req", imem_req, 1);
    go();
    chk("t7_pc", instr_pc, 32'hFFFF_FFFC);
    chk("t7_data", instr_data, mem_word(32'hFFFF_FFFC));

    // ---- misaligned redirect ----
    do_reset(1'b1, 1);
    repeat (3) go();
    branch_taken = 1'b1;
    branch_target = 32'h102;
    #1;
    chk("t6_br_req", imem_req, 0);
    go();
    branch_taken = 1'b0;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("t6_mis", misalign_err, 1);
    chk("t6_req", imem_req, 0);
    chk("t6_valid", instr_valid, 0);
    chk("t6_addr", imem_addr, 32'hC);
    for (int k = 0; k < 5; k++) begin
      go();
      chk("t6_halt_req", imem_req, 0);
      chk("t6_halt_valid", instr_valid, 0);
      chk("t6_halt_mis", misalign_err, 1);
    end
    do_reset(1'b1, 1);
    chk("t6_rst_mis", misalign_err, 0);
    chk("t6_rst_req", imem_req, 1);
    chk("t6_rst_addr", imem_addr, 32'h0);
`else
    chk("t6_mis", misalign_err, 0);
    chk("t6_addr", imem_addr, 32'h100);
    chk("t6_req", imem_req, 1);
    chk("t6_c4_valid", instr_valid, 0);
    go();
    chk("t6_c5_valid", instr_valid, 0);
    go();
    chk("t6_valid", instr_valid, 1);
    chk("t6_pc", instr_pc, 32'h100);
    chk("t6_data", instr_data, mem_word(32'h100));
`endif

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
